game_flow_ctrl: RTL

- Parametrised game-flow controller for the runner game. Sits between the pixel-level collision detectors (path/finish/coin/person masks) and the render/score logic.
- Adds, relative to the first-generation controller:
  - multiple lives
  - a timed respawn
  - an on-chip saturating score counter
  - a parametrised coin hold-off
  - edge-detected start/continue presses
  - deterministic event priority
- All outputs are registered.

---
 rtl/game_pkg.sv | 21 ++
 rtl/holdoff_timer.sv | 29 ++
 rtl/game_flow_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the runner-game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_RESPAWN = 3'd2,
        S_FINISH  = 3'd3,
        S_OVER    = 3'd4,
        S_PAUSED  = 3'd5
    } state_e;

    localparam int COIN_HOLDOFF_DEF  = 15000000;
    localparam int RESPAWN_TICKS_DEF = 50000000;

    // Bits needed to hold a down-count starting at n-1 (never less than 1).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Load/decrement down counter that parks at zero; used for coin hold-off
// and respawn delay. clear wins over load, load wins over freeze.
module holdoff_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         freeze_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Counter register: clear/load/hold/decrement-to-zero.
    always_ff @(posedge clk) begin
        if (reset || clear_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (!freeze_i && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: lives, timed respawn, saturating score, coin
// hold-off, edge-detected key presses. All outputs registered.
// Optional: GAME_PAUSE_TOGGLE_EN adds pause_key and a PAUSED state.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int SCORE_W       = 16,
    parameter int COIN_HOLDOFF  = COIN_HOLDOFF_DEF,
    parameter int RESPAWN_TICKS = RESPAWN_TICKS_DEF,
    parameter int LIVES_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic               person_on,
    input  logic               path_on,
    input  logic               finish_line,
    input  logic               coin_on,
    input  logic               fast_speed,
    input  logic               slow_speed,
    output logic               start_en,
    output logic               crash_en,
    output logic               finish_en,
    output logic               over_en,
    output logic               pause,
    output logic               reset_game,
    output logic               add_point,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives_left,
`ifdef GAME_PAUSE_TOGGLE_EN
    input  logic               pause_key,
`endif
    output logic [2:0]         state_o
);

    localparam int CW = cnt_w(COIN_HOLDOFF);
    localparam int RW = cnt_w(RESPAWN_TICKS);
    localparam logic [CW-1:0]      COIN_LOAD  = CW'(COIN_HOLDOFF - 1);
    localparam logic [RW-1:0]      RESP_LOAD  = RW'(RESPAWN_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_e state_q, state_d;
    logic start_q, start_d, crash_q, crash_d, fin_q, fin_d, over_q, over_d;
    logic pause_q, pause_d, rg_q, rg_d, add_q, add_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic key_q, press, ev, hit, fin, coin_ev, idle_vals;
    logic coin_load, coin_clear, coin_zero, resp_load, resp_zero, freeze;

    // Key history follows the live key even in reset, so a held key never
    // produces a press once reset drops.
    always_ff @(posedge clk) key_q <= fast_speed | slow_speed;

    assign press   = (fast_speed | slow_speed) & ~key_q;
    assign ev      = active & person_on;
    assign hit     = ev & ~path_on;
    assign fin     = ev & finish_line;
    assign coin_ev = ev & coin_on & coin_zero;

`ifdef GAME_PAUSE_TOGGLE_EN
    logic pk_q, pause_press;
    // Pause key history, same held-through-reset behaviour as the run keys.
    always_ff @(posedge clk) pk_q <= pause_key;
    assign pause_press = pause_key & ~pk_q;
    assign freeze      = (state_q == S_PAUSED);
`else
    assign freeze      = 1'b0;
`endif

    assign coin_clear = (state_q == S_IDLE);

    // Next state and next registered outputs; hit > fin > coin.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        crash_d   = crash_q;
        fin_d     = fin_q;
        over_d    = over_q;
        pause_d   = pause_q;
        rg_d      = rg_q;
        add_d     = 1'b0;
        score_d   = score_q;
        lives_d   = lives_q;
        coin_load = 1'b0;
        resp_load = 1'b0;
        idle_vals = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_vals = ~press;
                if (press) begin
                    state_d = S_RUN;
                    start_d = 1'b0;
                    pause_d = 1'b0;
                    rg_d    = 1'b0;
                end
            end
            S_RUN: begin
                start_d = 1'b0;
                pause_d = 1'b0;
                rg_d    = 1'b0;
                if (hit) begin
                    crash_d = 1'b1;
                    pause_d = 1'b1;
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d   = lives_q - 1'b1;
                        resp_load = 1'b1;
                        state_d   = S_RESPAWN;
                    end else begin
                        lives_d = '0;
                        over_d  = 1'b1;
                        state_d = S_OVER;
                    end
                end else if (fin) begin
                    fin_d   = 1'b1;
                    pause_d = 1'b1;
                    state_d = S_FINISH;
                end else if (coin_ev) begin
                    add_d     = 1'b1;
                    coin_load = 1'b1;
                    score_d   = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                end
`ifdef GAME_PAUSE_TOGGLE_EN
                else if (pause_press) begin
                    pause_d = 1'b1;
                    state_d = S_PAUSED;
                end
`endif
            end
            S_RESPAWN: begin
                pause_d = 1'b1;
                crash_d = 1'b1;
                rg_d    = 1'b0;
                if (resp_zero) begin
                    crash_d = 1'b0;
                    pause_d = 1'b0;
                    rg_d    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_FINISH, S_OVER: begin
                pause_d = 1'b1;
                if (press) begin
                    idle_vals = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`ifdef GAME_PAUSE_TOGGLE_EN
            S_PAUSED: begin
                pause_d = 1'b1;
                if (pause_press) begin
                    pause_d = 1'b0;
                    state_d = S_RUN;
                end
            end
`endif
            default: begin
                idle_vals = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
        if (idle_vals) begin
            start_d = 1'b1;
            pause_d = 1'b1;
            rg_d    = 1'b1;
            crash_d = 1'b0;
            fin_d   = 1'b0;
            over_d  = 1'b0;
            score_d = '0;
            lives_d = LIVES_INIT;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b1;
            pause_q <= 1'b1;
            rg_q    <= 1'b1;
            crash_q <= 1'b0;
            fin_q   <= 1'b0;
            over_q  <= 1'b0;
            add_q   <= 1'b0;
            score_q <= '0;
            lives_q <= LIVES_INIT;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            pause_q <= pause_d;
            rg_q    <= rg_d;
            crash_q <= crash_d;
            fin_q   <= fin_d;
            over_q  <= over_d;
            add_q   <= add_d;
            score_q <= score_d;
            lives_q <= lives_d;
        end
    end

    holdoff_timer #(.W(CW)) u_coin_tmr (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (coin_clear),
        .load_i     (coin_load),
        .load_val_i (COIN_LOAD),
        .freeze_i   (freeze),
        .zero_o     (coin_zero)
    );

    holdoff_timer #(.W(RW)) u_resp_tmr (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (1'b0),
        .load_i     (resp_load),
        .load_val_i (RESP_LOAD),
        .freeze_i   (freeze),
        .zero_o     (resp_zero)
    );

    assign start_en   = start_q;
    assign crash_en   = crash_q;
    assign finish_en  = fin_q;
    assign over_en    = over_q;
    assign pause      = pause_q;
    assign reset_game = rg_q;
    assign add_point  = add_q;
    assign score      = score_q;
    assign lives_left = lives_q;
    assign state_o    = state_q;

endmodule
